// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron_array block and its lanes.
package nn_pkg;

  localparam logic [1:0] ACT_LINEAR = 2'd0;
  localparam logic [1:0] ACT_RELU   = 2'd1;
  localparam logic [1:0] ACT_LEAKY  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_FINISH = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  // Accumulator width: full-width products plus headroom for n additions.
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/neuron_array_if.sv
// Input beat and output result handshake bundle for neuron_array.
interface neuron_array_if #(
  parameter int M  = 2,
  parameter int DW = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   start;
  logic signed [DW-1:0]   x;
  logic signed [M*DW-1:0] w;
  logic signed [M*DW-1:0] b;
  logic [1:0]             act_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [M*DW-1:0] activation;

  modport master (
    output in_valid, start, x, w, b, act_mode, out_ready,
    input  in_ready, out_valid, activation
  );

  modport slave (
    input  in_valid, start, x, w, b, act_mode, out_ready,
    output in_ready, out_valid, activation
  );
endinterface

// File: rtl/neuron_lane.sv
// One neuron: MAC accumulator plus bias, round-half-up, activation and saturation.
// Leaky ReLU (act_mode 2) is only built when LEAKY_RELU_EN is defined.
module neuron_lane
  import nn_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 accum,
  input  logic                 finish,
  input  logic [1:0]           mode,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] act
);
  localparam int ACC_W = acc_w(DW, N);
  localparam int T_W   = ACC_W + 1;
  localparam logic signed [T_W-1:0] HALF = T_W'(1) << (FRAC - 1);
  localparam logic signed [T_W-1:0] MAXV = {{(T_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [T_W-1:0] MINV = {{(T_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [DW-1:0]    bias_p0;
  logic signed [DW-1:0]    act_p1;

  assign prod     = x * w;
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign act      = act_p1;

  function automatic logic signed [T_W-1:0] round_bias(
    input logic signed [ACC_W-1:0] a,
    input logic signed [DW-1:0]    bb
  );
    logic signed [T_W-1:0] t;
    t = {{(T_W-ACC_W){a[ACC_W-1]}}, a}
      + ({{(T_W-DW){bb[DW-1]}}, bb} <<< FRAC)
      + HALF;
    return t >>> FRAC;
  endfunction

  function automatic logic signed [T_W-1:0] activate(
    input logic signed [T_W-1:0] y,
    input logic [1:0]            m
  );
    logic signed [T_W-1:0] r;
    r = y;
    if (m == ACT_RELU && y < 0) r = '0;
`ifdef LEAKY_RELU_EN
    if (m == ACT_LEAKY && y < 0) r = y >>> 3;
`endif
    return r;
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [T_W-1:0] y);
    logic signed [DW-1:0] r;
    if (y > MAXV)      r = {1'b0, {(DW-1){1'b1}}};
    else if (y < MINV) r = {1'b1, {(DW-1){1'b0}}};
    else               r = y[DW-1:0];
    return r;
  endfunction

  // Stage p0: accumulate beats; stage p1: registered activation result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0  <= '0;
      bias_p0 <= '0;
      act_p1  <= '0;
    end else begin
      if (load) begin
        acc_p0  <= prod_ext;
        bias_p0 <= b;
      end else if (accum) begin
        acc_p0 <= acc_p0 + prod_ext;
      end
      if (finish) act_p1 <= saturate(activate(round_bias(acc_p0, bias_p0), mode));
    end
  end

endmodule

// File: rtl/neuron_array.sv
// M neuron lanes sharing a serial x stream, with ready/valid on input and output.
// Optional leaky ReLU mode is enabled by defining LEAKY_RELU_EN.
module neuron_array
  import nn_pkg::*;
#(
  parameter int N    = 4,
  parameter int M    = 2,
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  neuron_array_if.slave  bus
);
  localparam int CNT_W = $clog2(N + 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           mode_p0;
  logic                 rdy_q;
  logic                 vld_p1;
  logic                 accept;
  logic                 load;
  logic                 accum;
  logic                 finish;
  logic [M-1:0][DW-1:0] act_arr;

  assign accept = bus.in_valid & rdy_q;
  assign load   = accept & bus.start;
  assign accum  = accept & ~bus.start & (state == S_ACCUM);
  assign finish = (state == S_FINISH);

  assign bus.in_ready   = rdy_q;
  assign bus.out_valid  = vld_p1;
  assign bus.activation = act_arr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mode_p0 <= '0;
      rdy_q   <= 1'b1;
      vld_p1  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          // A start beat restarts from either state; non-start beats in IDLE are dropped.
          if (load) begin
            cnt     <= CNT_W'(1);
            mode_p0 <= bus.act_mode;
            if (N == 1) begin
              state <= S_FINISH;
              rdy_q <= 1'b0;
            end else begin
              state <= S_ACCUM;
            end
          end else if (accum) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(N - 1)) begin
              state <= S_FINISH;
              rdy_q <= 1'b0;
            end
          end
        end
        S_FINISH: begin
          vld_p1 <= 1'b1;
          state  <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            vld_p1 <= 1'b0;
            rdy_q  <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_lane
    neuron_lane #(.N(N), .DW(DW), .FRAC(FRAC)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .accum  (accum),
      .finish (finish),
      .mode   (mode_p0),
      .x      (bus.x),
      .w      (bus.w[j*DW +: DW]),
      .b      (bus.b[j*DW +: DW]),
      .act    (act_arr[j])
    );
  end

endmodule

// File: doc/neuron_array.md
Name: neuron_array

Overview:
- Parametrised successor to the single streaming neuron: M independent neuron lanes share one serial input stream x and each owns a weight and bias.
- Computes act(sum over i<N of x_i*w_j,i + b_j) for every lane j. Arithmetic is signed fixed point (DW bits, FRAC fractional bits).
- Adds a ready/valid handshake on input and output, rounding, saturation and a runtime activation mode.
- Sits between the feature buffer and the next layer's input stream.

Parameters:
N, 4, inputs per neuron (beats per vector), >=1
M, 2, output lanes/neurons, >=1
DW, 16, data width of x, w, b, activation
FRAC, 8, fractional bits (Q(DW-FRAC).FRAC), 1..DW-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  beat on x/w is valid
in_ready  out  1  block accepts a beat this cycle
start  in  1  qualifies the first beat of a vector
x  in  DW  signed input element, shared by all lanes
w  in  M*DW  signed weights, lane j at [j*DW +: DW]
b  in  M*DW  signed biases, sampled on the start beat
act_mode  in  2  0 linear, 1 ReLU, 2 leaky ReLU (macro-gated), 3 reserved=linear; sampled on the start beat
out_valid  out  1  activation bus holds a result
out_ready  in  1  consumer takes the result
activation  out  M*DW  signed results, lane j at [j*DW +: DW]

Behaviour:
- Accept = in_valid & in_ready. Accumulator width ACC_W = 2*DW + $clog2(N) + 1; products are full 2*DW bits, sign-extended.
- States: IDLE, ACCUM, FINISH, OUT. in_ready is 1 in IDLE and ACCUM, 0 in FINISH and OUT.
- IDLE:
  - Accept with start: acc_j <= x*w_j, count <= 1, latch b and act_mode. Next state is FINISH if N==1, else ACCUM.
  - Accept without start: beat is dropped and the state does not change.
- ACCUM:
  - Accept without start: acc_j += x*w_j, count++. When count reaches N, go to FINISH.
  - Accept with start: restart the vector as in IDLE; the partial sum is discarded.
  - in_valid low: hold all state. Gaps of any length are legal.
- FINISH (one cycle), per lane:
  - t = acc_j + (b_j <<< FRAC) + (1 << (FRAC-1)), then y = t >>> FRAC (round half up).
  - Apply the activation to y.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1] and register into activation.
  - out_valid <= 1, go to OUT.
- OUT:
  - activation and out_valid are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - A new vector can be accepted from the next cycle.
- Latency: last beat accepted at cycle t, out_valid rises at t+2. Throughput is one vector per N+2 cycles with out_ready held at 1.
- ReLU: negative y becomes 0. Saturation is applied after the activation.
- Reset (any time, including mid-vector or during OUT):
  - state IDLE, acc and count 0, out_valid 0, activation 0, latched b/mode 0.
  - in_ready is 1 once rst_n deasserts.
- Simultaneous start and out_ready in OUT: start is not accepted, because in_ready=0.

Optional Feature:
- Macro LEAKY_RELU_EN.
- Defined: act_mode 2 gives y for y>=0 and y>>>3 (slope 1/8, arithmetic shift) for y<0.
- Undefined: act_mode 2 behaves as linear, and no leaky logic is synthesised.

Decomposition:
- Package nn_pkg holds:
  - act_mode constants ACT_LINEAR=0, ACT_RELU=1, ACT_LEAKY=2.
  - state encoding.
  - an ACC_W helper function.
- Sub-module neuron_lane: one MAC accumulator plus the round/bias/activation/saturate path, driven by shared control from neuron_array. The top level instantiates M lanes with a generate loop.

Test Plan (N=4, M=2, DW=16, FRAC=8):
- Basic, linear mode, no gaps:
  - Stimulus: x=[1,2,3,4]; lane0 w=[0.5,1.5,2.5,3.5], b=5; lane1 w=[-0.5,-1.5,-2.5,-3.5], b=-5.
  - Response: lane0 0x1E00 (30.0), lane1 0xE200 (-30.0); out_valid at last beat +2.
- Same vectors, act_mode=1: lane0 0x1E00, lane1 0x0000. With LEAKY_RELU_EN and act_mode=2: lane1 0xFC40 (-3.75).
- Saturation:
  - All x=127.0, w=127.0, b=0 gives 0x7FFF.
  - w=-127.0, linear, gives 0x8000.
- Stalls and backpressure:
  - Random in_valid gaps give the same 30.0.
  - out_ready low for 5 cycles: activation stable, in_ready 0, beats offered are not accepted.
- Restart and reset:
  - start reasserted on beat 3 causes the earlier partial sum to be discarded, and the result reflects only the new vector.
  - rst_n pulsed low mid-ACCUM: out_valid 0, activation 0, and the next full vector gives the correct result.
